// File: rtl/iterative_muldiv.sv
// iterative_muldiv: radix-2 multi-cycle MUL/UMULH/UDIV/SDIV unit for the LEGv8 datapath.
// Fixed WIDTH+1 cycle CALC phase (WIDTH steps plus one finalize edge), then a one-cycle FIN.
module iterative_muldiv #(
    parameter int WIDTH = 64
) (
    input  logic             Clk,
    input  logic             ResetL,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    input  logic [4:0]       RdIn,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [4:0]       RdOut,
    output logic             DivZero
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0] OP_MUL = 2'b00, OP_UMULH = 2'b01, OP_SDIV = 2'b11;

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
    state_t state, state_n;

    logic [1:0]       op;
    logic [4:0]       rd;
    logic             neg;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc, mq, b;
    logic [WIDTH-1:0] acc_n, mq_n, diff, fin;
    logic [WIDTH:0]   sum, sh;
    logic             is_div, ge, dz, last;

    // acc:mq is the product (high:low) for multiply, remainder:quotient for divide
    always_comb begin
        is_div = op[1];
        last   = cnt == CW'(WIDTH);
        sum    = {1'b0, acc} + (mq[0] ? {1'b0, b} : '0);
        sh     = {acc, mq[WIDTH-1]};
        ge     = sh >= {1'b0, b};
        diff   = sh[WIDTH-1:0] - b;
        acc_n  = is_div ? (ge ? diff : sh[WIDTH-1:0]) : sum[WIDTH:1];
        mq_n   = is_div ? {mq[WIDTH-2:0], ge} : {sum[0], mq[WIDTH-1:1]};
        dz     = is_div && b == '0;
        fin    = dz ? '0 : op == OP_MUL ? mq : op == OP_UMULH ? acc : neg ? -mq : mq;
    end

    always_comb begin
        state_n = IDLE;
        if (state == IDLE)
            state_n = Start ? CALC : IDLE;
        else if (state == CALC)
            state_n = last ? FIN : CALC;
    end

    always_ff @(posedge Clk or negedge ResetL)
        if (!ResetL)
            state <= IDLE;
        else
            state <= state_n;

    always_ff @(posedge Clk or negedge ResetL) begin
        if (!ResetL) begin
            op      <= '0;
            rd      <= '0;
            neg     <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            mq      <= '0;
            b       <= '0;
            Result  <= '0;
            RdOut   <= '0;
            DivZero <= 1'b0;
        end else if (state == IDLE && Start) begin
            op  <= Op;
            rd  <= RdIn;
            cnt <= '0;
            acc <= '0;
            // SDIV works on magnitudes; the sign is reapplied when finalizing
            neg <= Op == OP_SDIV && (OperandA[WIDTH-1] ^ OperandB[WIDTH-1]);
            mq  <= (Op == OP_SDIV && OperandA[WIDTH-1]) ? -OperandA : OperandA;
            b   <= (Op == OP_SDIV && OperandB[WIDTH-1]) ? -OperandB : OperandB;
        end else if (state == CALC) begin
            if (last) begin
                Result  <= fin;
                RdOut   <= rd;
                DivZero <= dz;
            end else begin
                acc <= acc_n;
                mq  <= mq_n;
            end
            cnt <= cnt + 1'b1;
        end
    end

    assign Busy = state != IDLE;
    assign Done = state == FIN;
endmodule
